// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, flag bit positions and FSM states for the multicycle ALU
package alu_pkg;
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_ACC = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_AVG = 3'd6,
      OP_DIV = 3'd7
   } alu_op_e;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock; quotient is presented in the cycle done is high
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic             div0
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, q, dvs;
   logic [WIDTH:0]   shifted, trial;
   assign shifted  = {rem, q[WIDTH-1]};
   assign trial    = shifted - {1'b0, dvs};
   assign done     = cnt == CW'(1);
   assign quotient = {q[WIDTH-2:0], ~trial[WIDTH]};
   // load operands on start, then shift one dividend bit into the partial remainder per clock
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt  <= '0;
         rem  <= '0;
         q    <= '0;
         dvs  <= '0;
         div0 <= 1'b0;
      end else if (start) begin
         cnt  <= CW'(WIDTH);
         rem  <= '0;
         q    <= dividend;
         dvs  <= divisor;
         div0 <= divisor == '0;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
         q   <= quotient;
      end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute ALU with single-cycle logic ops and iterative MUL/DIV/AVG
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e             state;
   alu_op_e            op_i, op_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mc, prod, prod_nxt;
   logic [WIDTH-1:0]   mp, op2, s_sum, dvd, dvs, quot, fin_r;
   logic [WIDTH:0]     sc;
   logic               sv, fin_c, fin_v, div_start, div_done, div0, iter, exec_done;
   logic [3:0]         fl;
   assign op_i      = alu_op_e'(op);
   assign iter      = op_i inside {OP_MUL, OP_DIV, OP_AVG};
   assign div_start = state == IDLE && in_valid && in_ready && (op_i == OP_DIV || op_i == OP_AVG);
   assign prod_nxt  = prod + (mp[0] ? mc : '0);
   assign exec_done = op_q == OP_MUL ? cnt == CW'(1) : div_done;
   // single-cycle datapath, byte-lane sum for AVG and the final result/flag selection
   always_comb begin
      s_sum = '0;
      for (int i = 0; i < LANES; i++) s_sum = s_sum + WIDTH'(a[8*i +: 8]);
      dvd = op_i == OP_AVG ? s_sum + WIDTH'(LANES / 2) : a;
      dvs = op_i == OP_AVG ? WIDTH'(LANES) : b;
      op2 = op_i == OP_ACC ? WIDTH'(b[7:0]) : b;
      sc  = op_i == OP_SUB ? {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1) :
            op_i == OP_AND ? {1'b0, a & b} :
            op_i == OP_OR  ? {1'b0, a | b} : {1'b0, a} + {1'b0, op2};
      sv  = op_i == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (sc[WIDTH-1] != a[WIDTH-1]) :
            (op_i == OP_ADD || op_i == OP_ACC) && (a[WIDTH-1] == op2[WIDTH-1]) && (sc[WIDTH-1] != a[WIDTH-1]);
      fin_r = state == EXEC ? (op_q == OP_MUL ? prod_nxt[WIDTH-1:0] : quot) : sc[WIDTH-1:0];
      fin_c = state == EXEC ? op_q == OP_MUL && |prod_nxt[2*WIDTH-1:WIDTH] : sc[WIDTH];
      fin_v = state == EXEC ? op_q == OP_DIV && div0 : sv;
      fl = '0;
      fl[FLAG_N] = fin_r[WIDTH-1];
      fl[FLAG_Z] = fin_r == '0;
      fl[FLAG_C] = fin_c;
      fl[FLAG_V] = fin_v;
   end
   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (dvd),
      .divisor  (dvs),
      .done     (div_done),
      .quotient (quot),
      .div0     (div0)
   );
   // control FSM with registered handshake outputs and the inline shift-add multiplier
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         op_q      <= OP_ADD;
         cnt       <= '0;
         mc        <= '0;
         mp        <= '0;
         prod      <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  op_q     <= op_i;
                  in_ready <= 1'b0;
                  if (iter) begin
                     state <= EXEC;
                     cnt   <= CW'(WIDTH);
                     mc    <= (2*WIDTH)'(a);
                     mp    <= b;
                     prod  <= '0;
                  end else begin
                     state     <= DONE;
                     result    <= fin_r;
                     flags     <= fl;
                     out_valid <= 1'b1;
                  end
               end
            end
            EXEC: begin
               prod <= prod_nxt;
               mc   <= mc << 1;
               mp   <= mp >> 1;
               cnt  <= cnt - CW'(1);
               if (exec_done) begin
                  state     <= DONE;
                  result    <= fin_r;
                  flags     <= fl;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random ops against an arithmetic reference model
module tb_alu_multicycle;
   localparam int W = 32;
   localparam int L = 3;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid;
   logic [2:0] op = '0;
   logic [W-1:0] a = '0, b = '0, result;
   logic [3:0] flags;
   int errs = 0, checks = 0;
   alu_multicycle #(.WIDTH(W), .LANES(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic bit ovf(input longint d);
      return d > 64'sd2147483647 || d < -64'sd2147483648;
   endfunction
   function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic [3:0] f);
      longint sx, sy;
      logic [63:0] u;
      logic c, v;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      c = 1'b0;
      v = 1'b0;
      u = '0;
      r = '0;
      case (o)
         3'd0: begin u = 64'(x) + 64'(y); r = u[31:0]; c = u[32]; v = ovf(sx + sy); end
         3'd1: begin r = x - y; c = x >= y; v = ovf(sx - sy); end
         3'd2: begin u = 64'(x) * 64'(y); r = u[31:0]; c = u[63:32] != 0; end
         3'd3: begin u = 64'(x) + 64'(y[7:0]); r = u[31:0]; c = u[32]; v = ovf(sx + longint'(y[7:0])); end
         3'd4: r = x & y;
         3'd5: r = x | y;
         3'd6: begin
            for (int i = 0; i < L; i++) u = u + 64'(x[8*i +: 8]);
            u = (u + 64'(L / 2)) / 64'(L);
            r = u[31:0];
         end
         default: if (y == 0) begin r = '1; v = 1'b1; end else r = x / y;
      endcase
      f = {r[31], r == 0, c, v};
   endfunction
   task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input int hold, input bit early);
      logic [W-1:0] er;
      logic [3:0] ef;
      int n;
      model(o, x, y, er, ef);
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("in_ready", 64'(in_ready), 1);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = early;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      n = 1;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("latency", 64'(n), (o == 3'd2 || o == 3'd6 || o == 3'd7) ? 64'd33 : 64'd1);
      check("result", 64'(result), 64'(er));
      check("flags", 64'(flags), 64'(ef));
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_result", 64'(result), 64'(er));
            check("hold_flags", 64'(flags), 64'(ef));
            check("hold_valid", 64'(out_valid), 1);
            check("hold_in_ready", 64'(in_ready), 0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("drain_valid", 64'(out_valid), 0);
      check("drain_in_ready", 64'(in_ready), 1);
   endtask
   initial begin
      int seen;
      logic [2:0] ro;
      logic [W-1:0] rb;
      #12;
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_result", 64'(result), 0);
      check("rst_flags", 64'(flags), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run(3'd0, 32'h7FFF_FFFF, 32'h1, 0, 0);
      check("add_lit", 64'(result), 64'h8000_0000);
      check("add_flags_lit", 64'(flags), 64'b1001);
      run(3'd1, 32'd5, 32'd5, 0, 0);
      check("sub_eq_flags_lit", 64'(flags), 64'b0110);
      run(3'd1, 32'd0, 32'd1, 0, 1);
      check("sub_neg_lit", 64'(result), 64'hFFFF_FFFF);
      run(3'd2, 32'h0001_0000, 32'h0001_0000, 0, 0);
      check("mul_flags_lit", 64'(flags), 64'b0110);
      run(3'd6, 32'h0003_0202, 32'h0, 0, 0);
      check("avg_lit", 64'(result), 64'd2);
      run(3'd6, 32'h00FF_FFFE, 32'h0, 0, 1);
      check("avg_max_lit", 64'(result), 64'hFF);
      run(3'd7, 32'd100, 32'd7, 0, 0);
      check("div_lit", 64'(result), 64'd14);
      run(3'd7, 32'h1234_5678, 32'd0, 0, 0);
      check("div0_lit", 64'(result), 64'hFFFF_FFFF);
      check("div0_v_lit", 64'(flags[0]), 1);
      run(3'd3, 32'h7FFF_FFF0, 32'hFFFF_FF20, 0, 0);
      run(3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0);
      run(3'd5, 32'h0, 32'h0, 0, 0);
      run(3'd0, 32'hFFFF_FFFF, 32'h1, 10, 0);
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 0);
      seen = 0;
      while (!in_ready && seen < 50) begin @(posedge clk); #1; seen++; end
      op = 3'd2; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 0);
      check("midrst_in_ready", 64'(in_ready), 0);
      check("midrst_result", 64'(result), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
      check("midrst_no_emit", 64'(seen), 0);
      run(3'd2, 32'h1234, 32'h5678, 0, 0);
      for (int k = 0; k < 150; k++) begin
         ro = 3'($urandom_range(0, 7));
         rb = $urandom_range(0, 7) == 0 ? '0 : $urandom >> $urandom_range(0, 31);
         run(ro, $urandom, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
